// File: rtl/m_unit_arbiter.sv
// rtl/m_unit_arbiter.sv - round-robin arbiter sharing one M-extension unit between two requesters
//
// Purpose: accept MUL/DIV/REM requests from two PCPI-style ports, grant one at
// a time (round-robin on ties), register its operands toward the M unit, and
// return the result to the winner. A watchdog aborts operations that never
// see m_ready and records the event in a sticky error flag.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   pN_valid/instruction/rs1/rs2       request from port N (N = 0, 1)
//   pN_busy                            combinational: port N holds an eligible request
//   pN_ready/wr/rd                     registered one-cycle completion toward port N
//   m_valid/instruction/rs1/rs2        registered request toward the M unit
//   m_ready/wr/rd                      response from the M unit
//   timeout_err                        sticky abort indicator
module m_unit_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic [31:0] p0_instruction,
  input  logic [31:0] p0_rs1,
  input  logic [31:0] p0_rs2,
  output logic        p0_busy,
  output logic        p0_ready,
  output logic        p0_wr,
  output logic [31:0] p0_rd,
  input  logic        p1_valid,
  input  logic [31:0] p1_instruction,
  input  logic [31:0] p1_rs1,
  input  logic [31:0] p1_rs2,
  output logic        p1_busy,
  output logic        p1_ready,
  output logic        p1_wr,
  output logic [31:0] p1_rd,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_ready,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [6:0] LP_OPCODE   = 7'b0110011;
  localparam logic [6:0] LP_FUNCT7   = 7'b0000001;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        r_last_grant;
  logic        r_mask0;
  logic        r_mask1;
  logic        r_timeout_err;
  logic        r_m_valid;
  logic [7:0]  r_cnt;
  logic [31:0] r_m_instruction;
  logic [31:0] r_m_rs1;
  logic [31:0] r_m_rs2;
  logic        r_p0_ready;
  logic        r_p0_wr;
  logic [31:0] r_p0_rd;
  logic        r_p1_ready;
  logic        r_p1_wr;
  logic [31:0] r_p1_rd;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_grant_go;
  logic        w_grant_sel;
  logic        w_done_ok;
  logic        w_done_to;

  // The mask hides a request for the one cycle after its ready strobe, so a
  // requester that has not yet dropped valid is not served a second time.
  assign w_elig0 = p0_valid && (p0_instruction[6:0] == LP_OPCODE)
                   && (p0_instruction[31:25] == LP_FUNCT7) && !r_mask0;
  assign w_elig1 = p1_valid && (p1_instruction[6:0] == LP_OPCODE)
                   && (p1_instruction[31:25] == LP_FUNCT7) && !r_mask1;

  assign p0_busy       = w_elig0;
  assign p1_busy       = w_elig1;
  assign p0_ready      = r_p0_ready;
  assign p0_wr         = r_p0_wr;
  assign p0_rd         = r_p0_rd;
  assign p1_ready      = r_p1_ready;
  assign p1_wr         = r_p1_wr;
  assign p1_rd         = r_p1_rd;
  assign m_valid       = r_m_valid;
  assign m_instruction = r_m_instruction;
  assign m_rs1         = r_m_rs1;
  assign m_rs2         = r_m_rs2;
  assign timeout_err   = r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_go  = 1'b0;
    w_grant_sel = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_grant_go  = 1'b1;
          // On a tie the port that did not win last time goes first.
          w_grant_sel = (w_elig0 && w_elig1) ? !r_last_grant : w_elig1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // m_ready takes priority over a watchdog expiry in the same cycle.
        if (m_ready) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_done_to   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_mask0         <= 1'b0;
      r_mask1         <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_m_valid       <= 1'b0;
      r_cnt           <= 8'd0;
      r_m_instruction <= 32'd0;
      r_m_rs1         <= 32'd0;
      r_m_rs2         <= 32'd0;
      r_p0_ready      <= 1'b0;
      r_p0_wr         <= 1'b0;
      r_p0_rd         <= 32'd0;
      r_p1_ready      <= 1'b0;
      r_p1_wr         <= 1'b0;
      r_p1_rd         <= 32'd0;
    end else begin
      // Completion outputs are single-cycle strobes and read 0 otherwise.
      r_p0_ready <= 1'b0;
      r_p0_wr    <= 1'b0;
      r_p0_rd    <= 32'd0;
      r_p1_ready <= 1'b0;
      r_p1_wr    <= 1'b0;
      r_p1_rd    <= 32'd0;
      r_mask0    <= r_p0_ready;
      r_mask1    <= r_p1_ready;

      if (w_grant_go) begin
        r_grant         <= w_grant_sel;
        r_last_grant    <= w_grant_sel;
        r_m_valid       <= 1'b1;
        r_cnt           <= 8'd0;
        r_m_instruction <= w_grant_sel ? p1_instruction : p0_instruction;
        r_m_rs1         <= w_grant_sel ? p1_rs1 : p0_rs1;
        r_m_rs2         <= w_grant_sel ? p1_rs2 : p0_rs2;
      end

      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_done_ok || w_done_to) begin
        r_m_valid <= 1'b0;
        r_cnt     <= 8'd0;
        if (r_grant) begin
          r_p1_ready <= 1'b1;
          r_p1_wr    <= w_done_ok && m_wr;
          r_p1_rd    <= w_done_ok ? m_rd : 32'd0;
        end else begin
          r_p0_ready <= 1'b1;
          r_p0_wr    <= w_done_ok && m_wr;
          r_p0_rd    <= w_done_ok ? m_rd : 32'd0;
        end
      end

      if (w_done_to) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

endmodule
